// File: rtl/avalon_gpio_pkg.sv
// Shared constants for the Avalon-MM GPIO bank: register map, width limits,
// synchroniser depth range and startup-guard sizing.
package avalon_gpio_pkg;

  localparam int unsigned MAX_WIDTH       = 32;
  localparam int unsigned ADDR_W          = 3;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 3;
  localparam int unsigned GUARD_W         = 3;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA     = 3'd0,
    ADDR_DIR      = 3'd1,
    ADDR_IRQ_MASK = 3'd2,
    ADDR_EDGE_CAP = 3'd3,
    ADDR_OUTSET   = 3'd4,
    ADDR_OUTCLEAR = 3'd5,
    ADDR_RISE_EN  = 3'd6,
    ADDR_FALL_EN  = 3'd7
  } gpio_addr_e;

  // Cycles after reset release during which edge detection is suppressed.
  function automatic int unsigned guard_cycles(input int unsigned stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/avalon_gpio_bank_if.sv
// Avalon-MM slave bus bundle for the GPIO bank (readLatency = 1, no wait states).
interface avalon_gpio_bank_if;
  import avalon_gpio_pkg::*;

  logic [ADDR_W-1:0]    address;
  logic                 chipselect;
  logic                 write_n;
  logic                 read_n;
  logic [MAX_WIDTH-1:0] writedata;
  logic [MAX_WIDTH-1:0] readdata;

  modport master (
    output address, chipselect, write_n, read_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, read_n, writedata,
    output readdata
  );

endinterface

// File: rtl/gpio_sync_edge.sv
// Input synchroniser, previous-sample register, startup guard and
// per-bit rising/falling edge generation for the GPIO bank.
module gpio_sync_edge
  import avalon_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [GUARD_W-1:0] GUARD_DONE = GUARD_W'(guard_cycles(SYNC_STAGES));

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  in_prev_q, in_prev_d;
  logic [GUARD_W-1:0]                guard_q, guard_d;
  logic                              guard_active;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], gpio_in};
    in_sync      = sync_q[SYNC_STAGES-1];
    in_prev_d    = in_sync;
    guard_active = (guard_q != GUARD_DONE);
    guard_d      = guard_active ? guard_q + 1'b1 : guard_q;
    // Guard masks the spurious 0->1 seen while the chain fills after reset.
    rise = in_sync & ~in_prev_q & rise_en & {WIDTH{~guard_active}};
    fall = ~in_sync & in_prev_q & fall_en & {WIDTH{~guard_active}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      in_prev_q <= '0;
      guard_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      in_prev_q <= in_prev_d;
      guard_q   <= guard_d;
    end
  end

endmodule

// File: rtl/avalon_gpio_bank.sv
// Avalon-MM GPIO bank: direction, atomic set/clear, synchronised inputs,
// edge capture with W1C and a registered maskable level interrupt.
module avalon_gpio_bank
  import avalon_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  avalon_gpio_bank_if.slave   avs,
  input  logic [WIDTH-1:0]    gpio_in,
  output logic [WIDTH-1:0]    gpio_out,
  output logic [WIDTH-1:0]    gpio_oe,
  output logic                irq
);

  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic [WIDTH-1:0]     dir_q, dir_d;
  logic [WIDTH-1:0]     irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]     edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0]     rise_en_q, rise_en_d;
  logic [WIDTH-1:0]     fall_en_q, fall_en_d;
  logic [MAX_WIDTH-1:0] readdata_q, readdata_d;
  logic                 irq_q, irq_d;

  logic                 wr_en, rd_en;
  logic [WIDTH-1:0]     wd, cap_clr, rd_field;
  logic [WIDTH-1:0]     in_sync, rise, fall;
  logic                 unused_wd;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio_in (gpio_in),
    .rise_en (rise_en_q),
    .fall_en (fall_en_q),
    .in_sync (in_sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign wr_en     = avs.chipselect & ~avs.write_n;
  assign rd_en     = avs.chipselect & ~avs.read_n;
  assign wd        = avs.writedata[WIDTH-1:0];
  assign unused_wd = ^{1'b0, avs.writedata};

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    cap_clr    = '0;
    if (wr_en) begin
      case (gpio_addr_e'(avs.address))
        ADDR_DATA:     data_out_d = wd;
        ADDR_DIR:      dir_d      = wd;
        ADDR_IRQ_MASK: irq_mask_d = wd;
        ADDR_EDGE_CAP: cap_clr    = wd;
        ADDR_OUTSET:   data_out_d = data_out_q | wd;
        ADDR_OUTCLEAR: data_out_d = data_out_q & ~wd;
        ADDR_RISE_EN:  rise_en_d  = wd;
        ADDR_FALL_EN:  fall_en_d  = wd;
        default:       data_out_d = data_out_q;
      endcase
    end
    // OR-ing new edges after the clear lets a same-cycle set win over W1C.
    edge_cap_d = (edge_cap_q & ~cap_clr) | rise | fall;
    irq_d      = |(edge_cap_q & irq_mask_q);
  end

  always_comb begin
    rd_field = '0;
    case (gpio_addr_e'(avs.address))
      ADDR_DATA:     rd_field = (dir_q & data_out_q) | (~dir_q & in_sync);
      ADDR_DIR:      rd_field = dir_q;
      ADDR_IRQ_MASK: rd_field = irq_mask_q;
      ADDR_EDGE_CAP: rd_field = edge_cap_q;
      ADDR_RISE_EN:  rd_field = rise_en_q;
      ADDR_FALL_EN:  rd_field = fall_en_q;
      default:       rd_field = '0;
    endcase
    readdata_d = readdata_q;
    if (rd_en) begin
      readdata_d              = '0;
      readdata_d[WIDTH-1:0]   = rd_field;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= OUT_RESET;
      dir_q      <= DIR_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign gpio_out     = data_out_q;
  assign gpio_oe      = dir_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_gpio_bank.sv
// Directed self-checking bench for avalon_gpio_bank (WIDTH=8, SYNC_STAGES=2).
module tb_avalon_gpio_bank;
  import avalon_gpio_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;
  logic [31:0] rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  avalon_gpio_bank_if avs ();

  avalon_gpio_bank #(
    .WIDTH       (8),
    .OUT_RESET   (8'hA5),
    .DIR_RESET   (8'hFF),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .avs      (avs),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    avs.chipselect = 1'b0;
    avs.write_n    = 1'b1;
    avs.read_n     = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avs.chipselect = 1'b1;
    avs.write_n    = 1'b0;
    avs.address    = a;
    avs.writedata  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avs.chipselect = 1'b1;
    avs.read_n     = 1'b0;
    avs.address    = a;
    @(negedge clk);
    bus_idle();
    d = avs.readdata;
  endtask

  initial begin
    reset_n       = 1'b0;
    gpio_in       = 8'h00;
    avs.address   = '0;
    avs.writedata = '0;
    bus_idle();

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gpio_out", {24'h0, gpio_out}, 32'hA5);
    chk("rst_gpio_oe", {24'h0, gpio_oe}, 32'hFF);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", avs.readdata, 32'h0);
    reset_n = 1'b1;
    rd(ADDR_DIR, rdata);
    chk("rd_dir_reset", rdata, 32'h0000_00FF);

    // Set / clear
    wr(ADDR_DATA, 32'hFFFF_FF0F);
    chk("data_write", {24'h0, gpio_out}, 32'h0F);
    wr(ADDR_OUTSET, 32'h0000_00F0);
    chk("outset", {24'h0, gpio_out}, 32'hFF);
    wr(ADDR_OUTCLEAR, 32'h0000_0003);
    chk("outclear", {24'h0, gpio_out}, 32'hFC);
    rd(ADDR_OUTSET, rdata);
    chk("rd_outset_zero", rdata, 32'h0);
    rd(ADDR_OUTCLEAR, rdata);
    chk("rd_outclear_zero", rdata, 32'h0);
    rd(ADDR_DATA, rdata);
    chk("rd_data_all_out", rdata, 32'h0000_00FC);

    // Direction read mux
    wr(ADDR_DIR, 32'h0000_000F);
    chk("oe_dir", {24'h0, gpio_oe}, 32'h0F);
    wr(ADDR_DATA, 32'h0000_00FF);
    gpio_in = 8'h50;
    repeat (4) @(negedge clk);
    rd(ADDR_DATA, rdata);
    chk("rd_data_mux", rdata, 32'h0000_005F);

    // Edge capture latency and irq latency, with EDGE_CAP read held every cycle
    wr(ADDR_RISE_EN, 32'h01);
    wr(ADDR_IRQ_MASK, 32'h01);
    chk("irq_before_edge", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    gpio_in        = 8'h51;
    avs.chipselect = 1'b1;
    avs.read_n     = 1'b0;
    avs.address    = ADDR_EDGE_CAP;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("cap_lat_c%0d", k), avs.readdata, (k == 4) ? 32'h1 : 32'h0);
      chk($sformatf("irq_lat_c%0d", k), {31'h0, irq}, (k == 4) ? 32'h1 : 32'h0);
    end
    avs.read_n    = 1'b1;
    avs.write_n   = 1'b0;
    avs.writedata = 32'h01;
    @(posedge clk); #1;
    bus_idle();
    chk("irq_w1c_c1", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    chk("irq_w1c_c2", {31'h0, irq}, 32'h0);

    // Set beats clear on a falling edge of bit 2
    wr(ADDR_FALL_EN, 32'h04);
    gpio_in = 8'h55;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    gpio_in = 8'h51;
    @(posedge clk); #1;
    @(posedge clk); #1;
    avs.chipselect = 1'b1;
    avs.write_n    = 1'b0;
    avs.address    = ADDR_EDGE_CAP;
    avs.writedata  = 32'h04;
    @(posedge clk); #1;
    bus_idle();
    rd(ADDR_EDGE_CAP, rdata);
    chk("set_beats_clear", rdata, 32'h04);
    chk("irq_unmasked_bit", {31'h0, irq}, 32'h0);
    wr(ADDR_EDGE_CAP, 32'h04);
    rd(ADDR_EDGE_CAP, rdata);
    chk("w1c_bit2", rdata, 32'h0);

    // Startup guard: pins high through reset, edges enabled right after release
    @(negedge clk);
    gpio_in = 8'hFF;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n        = 1'b1;
    avs.chipselect = 1'b1;
    avs.write_n    = 1'b0;
    avs.address    = ADDR_RISE_EN;
    avs.writedata  = 32'hFF;
    @(negedge clk);
    avs.address    = ADDR_IRQ_MASK;
    @(negedge clk);
    bus_idle();
    repeat (6) @(negedge clk);
    chk("guard_irq", {31'h0, irq}, 32'h0);
    rd(ADDR_EDGE_CAP, rdata);
    chk("guard_no_cap", rdata, 32'h0);

    // Reset mid-operation with irq asserted
    wr(ADDR_DATA, 32'h3C);
    wr(ADDR_DIR, 32'h00);
    chk("pre_rst_out", {24'h0, gpio_out}, 32'h3C);
    chk("pre_rst_oe", {24'h0, gpio_oe}, 32'h00);
    gpio_in = 8'hFE;
    repeat (4) @(negedge clk);
    gpio_in = 8'hFF;
    repeat (5) @(negedge clk);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    rd(ADDR_EDGE_CAP, rdata);
    chk("pre_rst_cap", rdata, 32'h01);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    chk("midrst_readdata", avs.readdata, 32'h0);
    chk("midrst_out", {24'h0, gpio_out}, 32'hA5);
    chk("midrst_oe", {24'h0, gpio_oe}, 32'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    rd(ADDR_EDGE_CAP, rdata);
    chk("postrst_cap", rdata, 32'h0);
    rd(ADDR_IRQ_MASK, rdata);
    chk("postrst_mask", rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_gpio_bank.md
# avalon_gpio_bank

Parametrised Avalon-MM general-purpose I/O bank that supersedes the fixed 8-bit output-only LED port. It provides per-bit direction control, atomic set/clear of output bits, synchronised input sampling, per-bit rising/falling edge capture and a maskable level interrupt to the Nios II. It sits on the Avalon-MM data master interconnect, with one instance per board I/O group (LEDs, switches, keys, headers).

## Interface
- WIDTH, 8: number of I/O bits, 1..32.
- OUT_RESET, 0: reset value of the output data register, WIDTH bits.
- DIR_RESET, 0: reset value of the direction register, where 1 = output.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  output data register.
- gpio_oe  out  WIDTH  output enable, equal to the direction register.
- irq  out  1  level interrupt, active-high.

## Operation
- A write occurs when chipselect=1 and write_n=0. A read occurs when chipselect=1 and read_n=0.
- Register map:
  - 0 DATA: write loads data_out. Read returns, per bit, dir ? data_out : in_sync.
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured bits. Writing 1 clears that bit; writing 0 has no effect.
  - 4 OUTSET: data_out |= wd. Reads return 0.
  - 5 OUTCLEAR: data_out &= ~wd. Reads return 0.
  - 6 RISE_EN: read/write.
  - 7 FALL_EN: read/write.
- Input path: gpio_in passes through a SYNC_STAGES flop chain to produce in_sync, then one more register produces in_prev.
- Edge detection:
  - rise = in_sync & ~in_prev & RISE_EN
  - fall = ~in_sync & in_prev & FALL_EN
  - Edge detection runs on all bits regardless of DIR.
- EDGE_CAP[i] is set on rise[i] | fall[i]. A set and a W1C on the same bit in the same cycle resolve with set winning.
- Startup guard: a counter runs SYNC_STAGES+1 cycles after reset release. While it runs, edge detection is suppressed, so a pin held high at reset is not captured. The counter then saturates and stays idle.
- irq is registered: irq <= |(EDGE_CAP & IRQ_MASK). It stays asserted until software clears the capture bits or the mask.
- A write to any register takes effect at the clk edge where it is sampled.
- Reset values:
  - data_out = OUT_RESET, DIR = DIR_RESET.
  - IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN, readdata, irq, synchroniser and in_prev all = 0.
- Reset asserted mid-operation clears all state asynchronously within the same cycle. Outputs take their reset values immediately.

## Timing
- Read latency is 1 cycle (Avalon readLatency=1). readdata is registered on the strobe edge and is valid the following cycle. It holds its value until the next read.
- There are no wait states. Back-to-back reads and writes are accepted every cycle.
- A write-then-read of the same register in consecutive cycles returns the new value.
- gpio_out and gpio_oe change 1 cycle after the write strobe is sampled.
- gpio_in toggle to EDGE_CAP set: SYNC_STAGES+1 cycles. To irq asserted: SYNC_STAGES+2 cycles.
- W1C of the last masked capture bit deasserts irq 2 cycles after the strobe.
- Pulses on gpio_in shorter than 1 clk period may be missed. Pulses of 2 or more cycles are captured.

## Structure
- A shared package avalon_gpio_pkg holds:
  - address constants ADDR_DATA .. ADDR_FALL_EN (3-bit)
  - MAX_WIDTH = 32
  - the SYNC_STAGES legal range
- One sub-module, gpio_sync_edge, parametrised by WIDTH and SYNC_STAGES. It contains:
  - the synchroniser chain
  - in_prev
  - the startup guard counter
  - rise/fall generation
- The top level holds the register file, read mux and irq.

## Test plan
- Reset values: with WIDTH=8, OUT_RESET=8'hA5, DIR_RESET=8'hFF, release reset → gpio_out=A5, gpio_oe=FF, irq=0. Read DIR → 0x000000FF one cycle after the strobe.
- Set/clear: write DATA=0x0F, OUTSET=0xF0, OUTCLEAR=0x03 → gpio_out=0x0F, then 0xFF, then 0xFC. Reads of OUTSET and OUTCLEAR return 0.
- Direction read mux: DIR=0x0F, data_out=0xFF, gpio_in=0x50 → DATA reads 0x5F.
- Edge capture and irq: RISE_EN=0x01, IRQ_MASK=0x01, drive gpio_in[0] 0→1 → EDGE_CAP=0x01 after 3 cycles and irq=1 after 4. Write EDGE_CAP=0x01 → irq=0 2 cycles later.
- Set beats clear: a falling edge on bit 2 (FALL_EN=0x04) reaches capture in the same cycle as a W1C to EDGE_CAP of 0x04 → EDGE_CAP[2]=1.
- Startup guard and reset mid-operation: hold gpio_in=0xFF through reset with RISE_EN=0xFF → no capture and irq=0. Assert reset_n mid-pulse with irq=1 → irq, EDGE_CAP and readdata all 0 in the same cycle.
